// File: rtl/s2p_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : s2p_frame_ctrl_if
// Description : Command, upstream, S2P and mapper signals of the S2P frame
//               sequencer, grouped with controller/environment modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface s2p_frame_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) ();
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_len;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              s2p_load;
    logic [DATA_W-1:0] s2p_data;
    logic              s2p_done;
    logic [DATA_W-1:0] s2p_out1;
    logic [DATA_W-1:0] s2p_out2;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [LEN_W-1:0]  pair_cnt;
    logic              frame_done;
    logic              err;

    // master is the frame controller; slave is everything around it
    modport master (
        input  cfg_start, cfg_len, abort, in_data, in_valid,
               s2p_done, s2p_out1, s2p_out2, out_ready,
        output in_ready, s2p_load, s2p_data, out_i, out_q, out_valid,
               busy, pair_cnt, frame_done, err
    );

    modport slave (
        output cfg_start, cfg_len, abort, in_data, in_valid,
               s2p_done, s2p_out1, s2p_out2, out_ready,
        input  in_ready, s2p_load, s2p_data, out_i, out_q, out_valid,
               busy, pair_cnt, frame_done, err
    );
endinterface
`default_nettype wire

// File: rtl/s2p_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : s2p_frame_ctrl
// Description : Frame sequencer feeding the serial-to-parallel register and
//               forwarding captured I/Q pairs to the mapper.
//               Optional macro S2P_TIMEOUT_EN adds a WAIT timeout with err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module s2p_frame_ctrl #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int WPS    = 2,
    parameter int TMO    = 15
) (
    input  logic             clk,
    input  logic             rst,
    s2p_frame_ctrl_if.master bus
);

    localparam int                  c_WCNT_W    = (WPS > 1) ? $clog2(WPS) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WPS - 1);

    if (WPS < 1 || TMO < 1) begin : g_param_check
        $error("s2p_frame_ctrl: WPS and TMO must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    r_pair_cnt;
    logic                r_s2p_load;
    logic [DATA_W-1:0]   r_s2p_data;
    logic [DATA_W-1:0]   r_out_i;
    logic [DATA_W-1:0]   r_out_q;
    logic                r_out_valid;
    logic                r_frame_done;

`ifdef S2P_TIMEOUT_EN
    localparam int                  c_TCNT_W    = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TMO - 1);

    logic [c_TCNT_W-1:0] r_tcnt;
    logic                r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wcnt       <= '0;
            r_remaining  <= '0;
            r_pair_cnt   <= '0;
            r_s2p_load   <= 1'b0;
            r_s2p_data   <= '0;
            r_out_i      <= '0;
            r_out_q      <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef S2P_TIMEOUT_EN
            r_tcnt       <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_s2p_load   <= 1'b0;
            r_frame_done <= 1'b0;
            // abort beats every handshake, including a same-cycle cfg_start
            if (bus.abort) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.cfg_start) begin
                            r_remaining <= bus.cfg_len;
                            r_pair_cnt  <= '0;
                            r_wcnt      <= '0;
`ifdef S2P_TIMEOUT_EN
                            r_err       <= 1'b0;
`endif
                            if (bus.cfg_len == '0) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (bus.in_valid) begin
                            r_s2p_data <= bus.in_data;
                            r_s2p_load <= 1'b1;
                            if (r_wcnt == c_WCNT_LAST) begin
                                r_wcnt  <= '0;
                                r_state <= S_WAIT;
`ifdef S2P_TIMEOUT_EN
                                r_tcnt  <= '0;
`endif
                            end else begin
                                r_wcnt <= r_wcnt + c_WCNT_W'(1);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (bus.s2p_done) begin
                            r_out_i     <= bus.s2p_out1;
                            r_out_q     <= bus.s2p_out2;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end
`ifdef S2P_TIMEOUT_EN
                        else if (r_tcnt == c_TCNT_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_tcnt <= r_tcnt + c_TCNT_W'(1);
                        end
`endif
                    end
                    S_OUT: begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_pair_cnt  <= r_pair_cnt + LEN_W'(1);
                            r_remaining <= r_remaining - LEN_W'(1);
                            r_wcnt      <= '0;
                            if (r_remaining == LEN_W'(1)) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = (r_state == S_LOAD);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.s2p_load   = r_s2p_load;
    assign bus.s2p_data   = r_s2p_data;
    assign bus.out_i      = r_out_i;
    assign bus.out_q      = r_out_q;
    assign bus.out_valid  = r_out_valid;
    assign bus.pair_cnt   = r_pair_cnt;
    assign bus.frame_done = r_frame_done;
`ifdef S2P_TIMEOUT_EN
    assign bus.err        = r_err;
`else
    assign bus.err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s2p_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2p_frame_ctrl
// Description : Directed plus randomized bench for s2p_frame_ctrl with an
//               emulated S2P register and a word-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2p_frame_ctrl;

    localparam int TMO = 15;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    s2p_frame_ctrl_if #(.DATA_W(16), .LEN_W(8)) bus ();

    s2p_frame_ctrl #(
        .DATA_W (16),
        .LEN_W  (8),
        .WPS    (2),
        .TMO    (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
        chk({tag, "_s2p_load"},   32'(bus.s2p_load),   32'd0);
        chk({tag, "_s2p_data"},   32'(bus.s2p_data),   32'd0);
        chk({tag, "_out_i"},      32'(bus.out_i),      32'd0);
        chk({tag, "_out_q"},      32'(bus.out_q),      32'd0);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_pair_cnt"},   32'(bus.pair_cnt),   32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_err"},        32'(bus.err),        32'd0);
    endtask

    // One frame: words come from a generated list, pair k must equal
    // (word 2k, word 2k+1). rmode: 0 ready always, 1 random, 2 stall pair 0.
    task automatic run_frame(input int len, input bit fixed, input int rmode, input int abort_at);
        logic [15:0] words[$];
        logic [15:0] emu_buf[2];
        logic [15:0] last_word;
        int widx, pairs_seen, loads, dones, rdy_high, busy_cycles;
        int emu_n, done_delay, stall, exp_pairs;
        bit finished, aborted;

        words = {};
        for (int k = 0; k < 2 * len; k++)
            words.push_back(fixed ? 16'((k + 1) * 32'h800) : 16'($urandom));
        last_word = '0;
        widx = 0; pairs_seen = 0; loads = 0; dones = 0; rdy_high = 0; busy_cycles = 0;
        emu_n = 0; done_delay = 0; stall = 0;
        finished = 1'b0; aborted = 1'b0;
        emu_buf[0] = '0; emu_buf[1] = '0;

        bus.cfg_len   = 8'(len);
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (bus.busy === 1'b1)       busy_cycles++;
            if (bus.in_ready === 1'b1)   rdy_high++;
            if (bus.frame_done === 1'b1) dones++;
            if (bus.s2p_load === 1'b1) begin
                loads++;
                chk("s2p_data", 32'(bus.s2p_data), 32'(last_word));
                if (emu_n < 2) emu_buf[emu_n] = bus.s2p_data;
                emu_n++;
                if (emu_n == 2) done_delay = $urandom_range(2, 4);
            end
            if (bus.out_valid === 1'b1) begin
                chk("in_ready_during_out", 32'(bus.in_ready), 32'd0);
                chk("pair_cnt_live", 32'(bus.pair_cnt), 32'(pairs_seen));
                if (pairs_seen < len) begin
                    chk("out_i", 32'(bus.out_i), 32'(words[2 * pairs_seen]));
                    chk("out_q", 32'(bus.out_q), 32'(words[2 * pairs_seen + 1]));
                end else begin
                    chk("extra_pair", 32'(pairs_seen), 32'(len - 1));
                end
            end

            if (bus.busy !== 1'b1) begin
                finished = 1'b1;
            end else begin
                bus.s2p_done = 1'b0;
                if (done_delay > 0) begin
                    done_delay--;
                    if (done_delay == 0) begin
                        bus.s2p_done = 1'b1;
                        bus.s2p_out1 = emu_buf[0];
                        bus.s2p_out2 = emu_buf[1];
                        emu_n = 0;
                    end
                end
                bus.in_valid = ($urandom_range(0, 3) != 0) && (widx < words.size());
                bus.in_data  = (widx < words.size()) ? words[widx] : 16'($urandom);
                case (rmode)
                    0:       bus.out_ready = 1'b1;
                    1:       bus.out_ready = 1'($urandom_range(0, 1));
                    default: bus.out_ready = !(bus.out_valid && pairs_seen == 0 && stall < 5);
                endcase
                if (rmode == 2 && bus.out_valid === 1'b1 && pairs_seen == 0 && stall < 5) stall++;
                if (abort_at >= 0 && !aborted && pairs_seen == abort_at && bus.in_ready === 1'b1) begin
                    bus.abort    = 1'b1;
                    bus.in_valid = 1'b0;
                    aborted      = 1'b1;
                end
                if (bus.in_valid && bus.in_ready === 1'b1) begin
                    last_word = bus.in_data;
                    widx++;
                end
                if (bus.out_valid === 1'b1 && bus.out_ready) pairs_seen++;
                @(negedge clk);
            end
        end

        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.s2p_done  = 1'b0;

        exp_pairs = (abort_at >= 0) ? abort_at : len;
        chk("frame_end", 32'(finished), 32'd1);
        chk("abort_taken", 32'(aborted), 32'(abort_at >= 0));
        chk("pair_cnt", 32'(bus.pair_cnt), 32'(exp_pairs));
        chk("pairs_seen", 32'(pairs_seen), 32'(exp_pairs));
        chk("frame_done_cnt", 32'(dones), (abort_at >= 0) ? 32'd0 : 32'd1);
        chk("idle_outputs", 32'({bus.in_ready, bus.s2p_load, bus.out_valid, bus.frame_done}), 32'd0);
        if (abort_at < 0) begin
            chk("words_used", 32'(widx), 32'(2 * len));
            chk("load_cnt", 32'(loads), 32'(2 * len));
        end
        if (len == 0) begin
            chk("len0_busy_cycles", 32'(busy_cycles), 32'd1);
            chk("len0_in_ready", 32'(rdy_high), 32'd0);
        end
        if (rmode == 2) chk("stall_cycles", 32'(stall), 32'd5);
        @(negedge clk);
    endtask

    initial begin
        int ok_cnt;
        int wait_cnt;
        int fd_cnt;

        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_len   = '0;
        bus.abort     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.s2p_done  = 1'b0;
        bus.s2p_out1  = '0;
        bus.s2p_out2  = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset("rst_init");
        rst = 1'b0;
        @(negedge clk);

        // reset while a frame is loading
        bus.cfg_len   = 8'd2;
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hA5A5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t1_s2p_load", 32'(bus.s2p_load), 32'd1);
        chk("t1_s2p_data", 32'(bus.s2p_data), 32'h0000A5A5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("t1_rst");
        rst = 1'b0;
        @(negedge clk);

        run_frame(2, 1'b1, 0, -1);        // fixed words 0x0800..0x2000
        run_frame(2, 1'b1, 2, -1);        // mapper stalls on first pair
        run_frame(0, 1'b0, 0, -1);        // empty frame
        run_frame(3, 1'b0, 1, 1);         // abort after first pair
        run_frame(3, 1'b0, 1, -1);        // recovers normally
        for (int i = 0; i < 5; i++)
            run_frame($urandom_range(1, 6), 1'b0, 1, -1);

        // S2P never answers
        bus.cfg_len   = 8'd1;
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        repeat (2) @(negedge clk);
        bus.in_valid  = 1'b0;
        chk("t6_in_wait_ready", 32'(bus.in_ready), 32'd0);
`ifdef S2P_TIMEOUT_EN
        wait_cnt = 0;
        fd_cnt   = 0;
        for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
            wait_cnt++;
            if (bus.frame_done === 1'b1) fd_cnt++;
            @(negedge clk);
        end
        chk("t6_wait_cycles", 32'(wait_cnt), 32'(TMO));
        chk("t6_err", 32'(bus.err), 32'd1);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_no_frame_done", 32'(fd_cnt), 32'd0);
        bus.cfg_len   = 8'd0;
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        chk("t6_err_cleared", 32'(bus.err), 32'd0);
        @(negedge clk);
        ok_cnt = 0;
`else
        ok_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy === 1'b1 && bus.err === 1'b0 && bus.in_ready === 1'b0 &&
                bus.out_valid === 1'b0)
                ok_cnt++;
            @(negedge clk);
        end
        chk("t6_wait_hold", 32'(ok_cnt), 32'd100);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t6_abort_busy", 32'(bus.busy), 32'd0);
        chk("t6_err", 32'(bus.err), 32'd0);
        wait_cnt = 0;
        fd_cnt   = 0;
`endif
        @(negedge clk);
        run_frame(2, 1'b0, 1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
